// File: rtl/prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package prefetch_queue_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DISCARD
   } state_t;

   localparam logic [31:0] RESET_VECTOR = 32'hFFFF_FFF0;

   function automatic logic [63:0] align_down(input logic [63:0] addr, input int unsigned bytes);
      return addr & ~(64'(bytes) - 64'd1);
   endfunction

endpackage

// File: rtl/prefetch_queue_byte_ring.sv
// Byte ring buffer: beat writes with a leading skip, variable-length retire, registered window.
module byte_ring_buffer
   import prefetch_queue_pkg::*;
#(
   parameter int unsigned BUS_BYTES   = 4,
   parameter int unsigned DEPTH_BYTES = 32,
   parameter int unsigned WINDOW      = 16,
   localparam int unsigned SW  = $clog2(BUS_BYTES),
   localparam int unsigned PW  = $clog2(DEPTH_BYTES),
   localparam int unsigned CW  = $clog2(DEPTH_BYTES + 1),
   localparam int unsigned WCW = $clog2(WINDOW + 1)
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   write_en,
   input  logic [BUS_BYTES*8-1:0] write_data,
   input  logic [SW-1:0]          write_skip,
   input  logic                   read_en,
   input  logic [4:0]             read_bytes,
   output logic [7:0]             window [0:WINDOW-1],
   output logic [WCW-1:0]         window_count,
   output logic [CW-1:0]          count,
   output logic [CW-1:0]          retired,
   output logic                   overrun
);

   logic [7:0]     mem       [DEPTH_BYTES];
   logic [7:0]     mem_n     [DEPTH_BYTES];
   logic [7:0]     window_n  [0:WINDOW-1];
   logic [PW-1:0]  rd_ptr, wr_ptr, rd_n, wr_n;
   logic [CW-1:0]  count_q, count_n, written, request;
   logic [WCW-1:0] window_count_n;
   logic           over;

   always_comb begin
      mem_n   = mem;
      rd_n    = rd_ptr;
      wr_n    = wr_ptr;
      count_n = count_q;
      written = '0;
      retired = '0;
      request = CW'(read_bytes);
      over    = 1'b0;
      if (clear) begin
         rd_n    = '0;
         wr_n    = '0;
         count_n = '0;
      end else begin
         // An oversized retire drains only what is present.
         if (read_en) begin
            over    = request > count_q;
            retired = over ? count_q : request;
         end
         if (write_en) begin
            written = CW'(BUS_BYTES) - CW'(write_skip);
            for (int unsigned i = 0; i < BUS_BYTES; i++) begin
               if (i >= 32'(write_skip)) begin
                  mem_n[wr_ptr + PW'(i - 32'(write_skip))] = write_data[8*i +: 8];
               end
            end
            wr_n = wr_ptr + PW'(written);
         end
         rd_n    = rd_ptr + PW'(retired);
         count_n = count_q + written - retired;
      end
   end

   always_comb begin
      for (int unsigned k = 0; k < WINDOW; k++) begin
         window_n[k] = (CW'(k) < count_n) ? mem_n[rd_n + PW'(k)] : '0;
      end
      window_count_n = (count_n > CW'(WINDOW)) ? WCW'(WINDOW) : WCW'(count_n);
   end

   always_ff @(posedge clock) begin
      mem <= mem_n;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         count_q      <= '0;
         window       <= '{default: '0};
         window_count <= '0;
         overrun      <= 1'b0;
      end else begin
         rd_ptr       <= rd_n;
         wr_ptr       <= wr_n;
         count_q      <= count_n;
         window       <= window_n;
         window_count <= window_count_n;
         overrun      <= over;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: bus fetch FSM, address generation and flush/redirect.
module prefetch_queue
   import prefetch_queue_pkg::*;
#(
   parameter int unsigned BUS_BYTES   = 4,
   parameter int unsigned DEPTH_BYTES = 32,
   parameter int unsigned WINDOW      = 16,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDRESS = ADDR_WIDTH'(RESET_VECTOR),
   localparam int unsigned SW  = $clog2(BUS_BYTES),
   localparam int unsigned CW  = $clog2(DEPTH_BYTES + 1),
   localparam int unsigned WCW = $clog2(WINDOW + 1)
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   fetch_enable,
   input  logic                   flush,
   input  logic [ADDR_WIDTH-1:0]  flush_address,
   output logic                   bus_vaild,
   input  logic                   bus_ready,
   output logic [ADDR_WIDTH-1:0]  bus_address,
   input  logic [BUS_BYTES*8-1:0] bus_data,
   output logic [7:0]             window [0:WINDOW-1],
   output logic [WCW-1:0]         window_count,
   output logic [ADDR_WIDTH-1:0]  window_address,
   input  logic                   consume_valid,
   input  logic [4:0]             consume_bytes,
   output logic                   overrun
);

   localparam logic [ADDR_WIDTH-1:0] RESET_ALIGNED =
      ADDR_WIDTH'(align_down(64'(RESET_ADDRESS), BUS_BYTES));
   localparam logic [CW-1:0] SPACE_LIMIT = CW'(DEPTH_BYTES - BUS_BYTES);

   state_t                state, state_next;
   logic [ADDR_WIDTH-1:0] fetch_addr, fetch_addr_next, req_addr, win_addr;
   logic [SW-1:0]         skip, skip_next;
   logic [CW-1:0]         count, retired, written;
   logic                  write_en;

   assign written = CW'(BUS_BYTES) - CW'(skip);

   always_comb begin
      state_next      = state;
      write_en        = 1'b0;
      fetch_addr_next = fetch_addr;
      skip_next       = skip;
      case (state)
         S_IDLE: begin
            if (!flush && fetch_enable && count <= SPACE_LIMIT) state_next = S_FETCH;
         end
         S_FETCH: begin
            if (flush) begin
               state_next = bus_ready ? S_IDLE : S_DISCARD;
            end else if (bus_ready) begin
               write_en        = 1'b1;
               fetch_addr_next = fetch_addr + ADDR_WIDTH'(BUS_BYTES);
               skip_next       = '0;
               state_next      = (fetch_enable && (count + written) <= SPACE_LIMIT) ? S_FETCH : S_IDLE;
            end
         end
         S_DISCARD: begin
            if (bus_ready) state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (flush) begin
         fetch_addr_next = ADDR_WIDTH'(align_down(64'(flush_address), BUS_BYTES));
         skip_next       = flush_address[SW-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   // The request address stays frozen while a discarded request drains.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fetch_addr <= RESET_ALIGNED;
         req_addr   <= RESET_ALIGNED;
         skip       <= RESET_ADDRESS[SW-1:0];
         win_addr   <= RESET_ADDRESS;
      end else begin
         fetch_addr <= fetch_addr_next;
         skip       <= skip_next;
         if (state_next != S_DISCARD) req_addr <= fetch_addr_next;
         if (flush) win_addr <= flush_address;
         else       win_addr <= win_addr + ADDR_WIDTH'(retired);
      end
   end

   assign bus_vaild      = (state != S_IDLE);
   assign bus_address    = req_addr;
   assign window_address = win_addr;

   byte_ring_buffer #(
      .BUS_BYTES  (BUS_BYTES),
      .DEPTH_BYTES(DEPTH_BYTES),
      .WINDOW     (WINDOW)
   ) u_ring (
      .clock       (clock),
      .reset       (reset),
      .clear       (flush),
      .write_en    (write_en),
      .write_data  (bus_data),
      .write_skip  (skip),
      .read_en     (consume_valid),
      .read_bytes  (consume_bytes),
      .window      (window),
      .window_count(window_count),
      .count       (count),
      .retired     (retired),
      .overrun     (overrun)
   );

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue against a byte-queue reference model.
module tb_prefetch_queue;

   logic        clock = 1'b0;
   logic        reset;
   logic        fetch_enable;
   logic        flush;
   logic [31:0] flush_address;
   logic        bus_vaild;
   logic        bus_ready;
   logic [31:0] bus_address;
   logic [31:0] bus_data;
   logic [7:0]  window [0:15];
   logic [4:0]  window_count;
   logic [31:0] window_address;
   logic        consume_valid;
   logic [4:0]  consume_bytes;
   logic        overrun;

   int total = 0;
   int bad   = 0;

   byte unsigned mq[$];
   logic [31:0]  m_head, m_tail;
   bit           m_discard, m_over;

   always #5 clock = ~clock;

   prefetch_queue #(
      .BUS_BYTES(4), .DEPTH_BYTES(32), .WINDOW(16), .ADDR_WIDTH(32), .RESET_ADDRESS(32'hFFFF_FFF0)
   ) dut (
      .clock(clock), .reset(reset), .fetch_enable(fetch_enable), .flush(flush),
      .flush_address(flush_address), .bus_vaild(bus_vaild), .bus_ready(bus_ready),
      .bus_address(bus_address), .bus_data(bus_data), .window(window),
      .window_count(window_count), .window_address(window_address),
      .consume_valid(consume_valid), .consume_bytes(consume_bytes), .overrun(overrun)
   );

   task automatic model_reset();
      mq.delete();
      m_head = 32'hFFFF_FFF0;
      m_tail = 32'hFFFF_FFF0;
      m_discard = 0;
      m_over = 0;
   endtask

   // Applies this cycle's inputs to the model, then advances the clock.
   task automatic tick();
      int n;
      m_over = 0;
      if (flush) begin
         mq.delete();
         m_head = flush_address;
         m_tail = flush_address;
         m_discard = bus_vaild && !bus_ready;
      end else begin
         if (consume_valid) begin
            n = int'(consume_bytes);
            if (n > mq.size()) begin
               m_over = 1;
               n = mq.size();
            end
            repeat (n) void'(mq.pop_front());
            m_head = m_head + 32'(n);
         end
         if (bus_vaild && bus_ready) begin
            if (m_discard) m_discard = 0;
            else begin
               for (int i = int'(m_tail[1:0]); i < 4; i++) mq.push_back(bus_data[8*i +: 8]);
               m_tail = {m_tail[31:2], 2'b00} + 32'd4;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic wait_valid(input int bound, output bit ok);
      ok = 0;
      for (int c = 0; c <= bound; c++) begin
         if (bus_vaild) begin
            ok = 1;
            break;
         end
         if (c < bound) tick();
      end
   endtask

   task automatic test_reset();
      reset = 0; fetch_enable = 0; flush = 0; flush_address = '0; bus_ready = 0;
      bus_data = '0; consume_valid = 0; consume_bytes = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      total++; if (bus_vaild !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", bus_vaild); end
      total++; if (bus_address !== 32'hFFFF_FFF0) begin bad++; $display("FAIL reset_busaddr got=%h want=fffffff0", bus_address); end
      total++; if (window_count !== 5'd0) begin bad++; $display("FAIL reset_wcount got=%0d want=0", window_count); end
      total++; if (window_address !== 32'hFFFF_FFF0) begin bad++; $display("FAIL reset_waddr got=%h want=fffffff0", window_address); end
      total++; if (overrun !== 1'b0 || window[0] !== 8'h00) begin bad++; $display("FAIL reset_misc got=%0b/%h want=0/00", overrun, window[0]); end
      reset = 1;
   endtask

   task automatic test_first_beat();
      bit ok;
      fetch_enable = 1;
      wait_valid(5, ok);
      total++; if (!ok) begin bad++; $display("FAIL first_req_timeout got=0 want=1"); end
      total++; if (bus_address !== 32'hFFFF_FFF0) begin bad++; $display("FAIL first_addr got=%h want=fffffff0", bus_address); end
      bus_data = 32'h4433_2211; bus_ready = 1;
      tick();
      bus_ready = 0;
      total++; if ({window[0], window[1], window[2], window[3]} !== 32'h1122_3344) begin
         bad++; $display("FAIL first_bytes got=%h %h %h %h want=11 22 33 44", window[0], window[1], window[2], window[3]); end
      total++; if (window_count !== 5'd4) begin bad++; $display("FAIL first_wcount got=%0d want=4", window_count); end
      total++; if (window_address !== 32'hFFFF_FFF0) begin bad++; $display("FAIL first_waddr got=%h want=fffffff0", window_address); end
   endtask

   task automatic test_fill();
      int beats = 0;
      bit done = 0;
      bus_ready = 1;
      for (int c = 0; c < 20 && !done; c++) begin
         bus_data = $urandom;
         if (bus_vaild) begin
            beats++;
            tick();
         end else done = 1;
      end
      total++; if (beats != 7 || bus_vaild !== 1'b0) begin bad++; $display("FAIL fill_beats got=%0d/%0b want=7/0", beats, bus_vaild); end
      tick();
      total++; if (bus_vaild !== 1'b0) begin bad++; $display("FAIL fill_stays_idle got=%0b want=0", bus_vaild); end
      total++; if (window_count !== 5'd16) begin bad++; $display("FAIL fill_wcount got=%0d want=16", window_count); end
      for (int i = 0; i < 16; i++) begin
         total++; if (window[i] !== mq[i]) begin bad++; $display("FAIL fill_byte%0d got=%h want=%h", i, window[i], mq[i]); end
      end
      bus_ready = 0;
   endtask

   task automatic test_consume();
      bit ok;
      consume_valid = 1; consume_bytes = 5;
      tick();
      consume_valid = 0;
      total++; if (window_address !== 32'hFFFF_FFF5) begin bad++; $display("FAIL consume_waddr got=%h want=fffffff5", window_address); end
      total++; if (window[0] !== mq[0]) begin bad++; $display("FAIL consume_byte0 got=%h want=%h", window[0], mq[0]); end
      wait_valid(3, ok);
      total++; if (!ok) begin bad++; $display("FAIL consume_refetch got=0 want=1"); end
      total++; if (bus_address !== 32'h0000_0010) begin bad++; $display("FAIL consume_refetch_addr got=%h want=00000010", bus_address); end
   endtask

   task automatic test_flush_discard();
      bit ok;
      flush = 1; flush_address = 32'h0000_1003;
      tick();
      flush = 0;
      tick();
      total++; if (bus_vaild !== 1'b1 || bus_address !== 32'h0000_0010) begin
         bad++; $display("FAIL flush_hold got=%0b/%h want=1/00000010", bus_vaild, bus_address); end
      total++; if (window_count !== 5'd0 || window_address !== 32'h0000_1003) begin
         bad++; $display("FAIL flush_window got=%0d/%h want=0/00001003", window_count, window_address); end
      bus_data = 32'hDEAD_BEEF; bus_ready = 1;
      tick();
      bus_ready = 0;
      total++; if (window_count !== 5'd0) begin bad++; $display("FAIL flush_drop got=%0d want=0", window_count); end
      wait_valid(4, ok);
      total++; if (!ok || bus_address !== 32'h0000_1000) begin bad++; $display("FAIL flush_refetch got=%0b/%h want=1/00001000", ok, bus_address); end
      bus_data = 32'hDDCC_BBAA; bus_ready = 1;
      tick();
      bus_ready = 0;
      total++; if (window[0] !== 8'hDD || window[1] !== 8'h00) begin bad++; $display("FAIL flush_skip_bytes got=%h %h want=dd 00", window[0], window[1]); end
      total++; if (window_count !== 5'd1 || window_address !== 32'h0000_1003) begin
         bad++; $display("FAIL flush_skip_state got=%0d/%h want=1/00001003", window_count, window_address); end
   endtask

   task automatic test_overrun();
      bit ok;
      fetch_enable = 0;
      flush = 1; flush_address = 32'h0000_2001;
      tick();
      flush = 0;
      bus_ready = 1;
      tick();
      bus_ready = 0;
      fetch_enable = 1;
      wait_valid(4, ok);
      fetch_enable = 0;
      bus_data = $urandom; bus_ready = 1;
      tick();
      bus_ready = 0;
      total++; if (!ok || window_count !== 5'd3) begin bad++; $display("FAIL overrun_setup got=%0d want=3", window_count); end
      consume_valid = 1; consume_bytes = 7;
      tick();
      consume_valid = 0;
      total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse got=%0b want=1", overrun); end
      total++; if (window_count !== 5'd0 || window_address !== 32'h0000_2004) begin
         bad++; $display("FAIL overrun_state got=%0d/%h want=0/00002004", window_count, window_address); end
      tick();
      total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_one_cycle got=%0b want=0", overrun); end
   endtask

   task automatic test_async_reset();
      bit ok;
      fetch_enable = 1;
      wait_valid(4, ok);
      bus_data = $urandom; bus_ready = 1;
      tick();
      total++; if (!ok || bus_vaild !== 1'b1 || window_count !== 5'd4) begin
         bad++; $display("FAIL areset_setup got=%0b/%0d want=1/4", bus_vaild, window_count); end
      #2;
      reset = 0;
      #1;
      total++; if (bus_vaild !== 1'b0 || window_count !== 5'd0) begin
         bad++; $display("FAIL areset_immediate got=%0b/%0d want=0/0", bus_vaild, window_count); end
      total++; if (window_address !== 32'hFFFF_FFF0 || bus_address !== 32'hFFFF_FFF0) begin
         bad++; $display("FAIL areset_addr got=%h/%h want=fffffff0", window_address, bus_address); end
      bus_ready = 0; fetch_enable = 0;
      @(posedge clock);
      #1;
      reset = 1;
      model_reset();
   endtask

   task automatic test_random();
      bit          hold;
      logic [31:0] hold_addr;
      int          wbad;
      for (int c = 0; c < 1500; c++) begin
         fetch_enable  = ($urandom_range(9, 0) < 8);
         bus_ready     = $urandom_range(1, 0);
         bus_data      = $urandom;
         consume_valid = $urandom_range(1, 0);
         consume_bytes = 5'($urandom_range(16, 0));
         flush         = ($urandom_range(39, 0) == 0);
         flush_address = $urandom;
         if (bus_vaild && !m_discard) begin
            total++; if (bus_address !== {m_tail[31:2], 2'b00}) begin
               bad++; $display("FAIL rnd_busaddr c=%0d got=%h want=%h", c, bus_address, {m_tail[31:2], 2'b00}); end
         end
         hold = bus_vaild && !bus_ready;
         hold_addr = bus_address;
         tick();
         if (hold) begin
            total++; if (bus_vaild !== 1'b1 || bus_address !== hold_addr) begin
               bad++; $display("FAIL rnd_hold c=%0d got=%0b/%h want=1/%h", c, bus_vaild, bus_address, hold_addr); end
         end
         total++; if (window_count !== 5'((mq.size() > 16) ? 16 : mq.size())) begin
            bad++; $display("FAIL rnd_wcount c=%0d got=%0d want=%0d", c, window_count, (mq.size() > 16) ? 16 : mq.size()); end
         total++; if (window_address !== m_head) begin bad++; $display("FAIL rnd_waddr c=%0d got=%h want=%h", c, window_address, m_head); end
         total++; if (overrun !== m_over) begin bad++; $display("FAIL rnd_overrun c=%0d got=%0b want=%0b", c, overrun, m_over); end
         wbad = 0;
         for (int i = 0; i < 16; i++) begin
            if (window[i] !== ((i < mq.size()) ? mq[i] : 8'h00)) wbad++;
         end
         total++; if (wbad != 0) begin bad++; $display("FAIL rnd_window c=%0d got=%0d_bad_bytes want=0 w0=%h", c, wbad, window[0]); end
      end
      flush = 0; consume_valid = 0; bus_ready = 0;
   endtask

   initial begin
      test_reset();
      test_first_beat();
      test_fill();
      test_consume();
      test_flush_discard();
      test_overrun();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
